// File: rtl/elevator_scan_ctrl.sv
// SCAN-order elevator car controller: latches floor calls in a pending bitmap,
// travels one floor per TRAVEL_CYCLES, dwells DOOR_CYCLES at stops, freezes on emergency.
module elevator_scan_ctrl #(
   parameter int NUM_FLOORS    = 8,
   parameter int FLOOR_W       = $clog2(NUM_FLOORS),
   parameter int TRAVEL_CYCLES = 2,
   parameter int DOOR_CYCLES   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  emergency,
   input  logic                  call_valid,
   input  logic [FLOOR_W-1:0]    call_floor,
   output logic [FLOOR_W-1:0]    floor,
   output logic                  door,
   output logic                  direction,
   output logic                  moving,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam int TW = $clog2(TRAVEL_CYCLES + 1);
   localparam int DW = $clog2(DOOR_CYCLES + 1);
   localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVE      = 2'd1,
      DOOR_OPEN = 2'd2,
      EMERG     = 2'd3
   } state_t;

   state_t        state;
   logic [TW-1:0] travel_cnt;
   logic [DW-1:0] door_cnt;

   function automatic logic any_above(input logic [NUM_FLOORS-1:0] p,
                                      input logic [FLOOR_W-1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (i > int'(f) && p[i]) r = 1'b1;
      return r;
   endfunction

   function automatic logic any_below(input logic [NUM_FLOORS-1:0] p,
                                      input logic [FLOOR_W-1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (i < int'(f) && p[i]) r = 1'b1;
      return r;
   endfunction

   // Calls are dropped while the emergency input or EMERG state is active.
   logic                  call_ok;
   logic                  here_call;
   logic [NUM_FLOORS-1:0] call_bit;
   logic [NUM_FLOORS-1:0] here_bit;
   logic [NUM_FLOORS-1:0] pend_in;
   logic [FLOOR_W-1:0]    floor_nx;
   logic [NUM_FLOORS-1:0] nx_bit;
   logic                  dir_arr;
   logic                  ahead_nx;
   logic                  behind_nx;
   logic                  idle_dir;
   logic                  last_travel;
   logic                  last_dwell;

   assign call_ok   = call_valid && !emergency && (state != EMERG) &&
                      (int'(call_floor) < NUM_FLOORS);
   assign here_call = call_ok && (call_floor == floor) &&
                      ((state == IDLE) || (state == DOOR_OPEN));
   assign call_bit  = call_ok ? (NUM_FLOORS'(1) << call_floor) : '0;
   assign here_bit  = NUM_FLOORS'(1) << floor;
   assign pend_in   = pending | (here_call ? '0 : call_bit);

   assign floor_nx  = (direction && floor != TOP)  ? floor + 1'b1 :
                      (!direction && floor != '0)  ? floor - 1'b1 : floor;
   assign nx_bit    = NUM_FLOORS'(1) << floor_nx;
   // Reaching either end forces the direction to point back inward.
   assign dir_arr   = (floor_nx == TOP) ? 1'b0 : (floor_nx == '0) ? 1'b1 : direction;
   assign ahead_nx  = dir_arr ? any_above(pend_in, floor_nx) : any_below(pend_in, floor_nx);
   assign behind_nx = dir_arr ? any_below(pend_in, floor_nx) : any_above(pend_in, floor_nx);
   assign idle_dir  = direction ? any_above(pending, floor) : !any_below(pending, floor);

   assign last_travel = (travel_cnt == TW'(TRAVEL_CYCLES - 1));
   assign last_dwell  = (door_cnt == DW'(DOOR_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         floor      <= '0;
         door       <= 1'b1;
         direction  <= 1'b1;
         moving     <= 1'b0;
         pending    <= '0;
         travel_cnt <= '0;
         door_cnt   <= '0;
      end else if (emergency) begin
         state      <= EMERG;
         door       <= 1'b1;
         moving     <= 1'b0;
         travel_cnt <= '0;
         door_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               pending <= pend_in;
               if (here_call) begin
                  state    <= DOOR_OPEN;
                  door_cnt <= '0;
               end else if ((pending & here_bit) != '0) begin
                  // A stale call for the current floor is simply served here.
                  pending  <= pend_in & ~here_bit;
                  state    <= DOOR_OPEN;
                  door_cnt <= '0;
               end else if (pending != '0) begin
                  state      <= MOVE;
                  door       <= 1'b0;
                  moving     <= 1'b1;
                  travel_cnt <= '0;
                  direction  <= idle_dir;
               end
            end
            MOVE: begin
               pending <= pend_in;
               if (last_travel) begin
                  floor      <= floor_nx;
                  travel_cnt <= '0;
                  if ((pend_in & nx_bit) != '0) begin
                     pending   <= pend_in & ~nx_bit;
                     state     <= DOOR_OPEN;
                     door      <= 1'b1;
                     moving    <= 1'b0;
                     door_cnt  <= '0;
                     direction <= dir_arr;
                  end else if (ahead_nx) begin
                     direction <= dir_arr;
                  end else if (behind_nx) begin
                     direction <= ~dir_arr;
                  end else begin
                     state     <= IDLE;
                     door      <= 1'b1;
                     moving    <= 1'b0;
                     direction <= dir_arr;
                  end
               end else begin
                  travel_cnt <= travel_cnt + 1'b1;
               end
            end
            DOOR_OPEN: begin
               pending <= pend_in;
               if (here_call)       door_cnt <= '0;
               else if (last_dwell) state    <= IDLE;
               else                 door_cnt <= door_cnt + 1'b1;
            end
            default: begin
               state <= IDLE;
               door  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl: reset, SCAN order, door dwell, emergency,
// floor bounds and asynchronous reset, with hand-computed expectations.
module tb_elevator_scan_ctrl;

   localparam logic [1:0] S_IDLE = 2'd0, S_MOVE = 2'd1, S_DOOR = 2'd2, S_EMERG = 2'd3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       emergency = 1'b0;
   logic       call_valid = 1'b0;
   logic [2:0] call_floor = '0;
   logic [2:0] floor;
   logic       door, direction, moving;
   logic [7:0] pending;

   logic       call_valid2 = 1'b0;
   logic [2:0] call_floor2 = '0;
   logic [2:0] floor2;
   logic       door2, direction2, moving2;
   logic [5:0] pending2;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;
   int prev_floor;
   int rises;

   elevator_scan_ctrl dut (
      .clk(clk), .rst(rst), .emergency(emergency), .call_valid(call_valid),
      .call_floor(call_floor), .floor(floor), .door(door), .direction(direction),
      .moving(moving), .pending(pending)
   );

   // Six-floor instance so that out-of-range floor codes are representable.
   elevator_scan_ctrl #(.NUM_FLOORS(6)) dut6 (
      .clk(clk), .rst(rst), .emergency(1'b0), .call_valid(call_valid2),
      .call_floor(call_floor2), .floor(floor2), .door(door2), .direction(direction2),
      .moving(moving2), .pending(pending2)
   );

   logic [1:0] st;
   assign st = dut.state;

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic call(input logic [2:0] f);
      call_valid = 1'b1;
      call_floor = f;
      step(1);
      call_valid = 1'b0;
   endtask

   task automatic wait_state(input logic [1:0] target, input int budget, output int c);
      c = 0;
      while (st !== target && c < budget) begin
         step(1);
         c++;
      end
   endtask

   task automatic wait_floor(input logic [2:0] target, input int budget, output int c);
      c = 0;
      while (floor !== target && c < budget) begin
         step(1);
         c++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_floor"}, 32'(floor), 32'd0);
      check({tag, "_door"}, 32'(door), 32'd1);
      check({tag, "_dir"}, 32'(direction), 32'd1);
      check({tag, "_moving"}, 32'(moving), 32'd0);
      check({tag, "_pending"}, 32'(pending), 32'd0);
      check({tag, "_state"}, 32'(st), 32'(S_IDLE));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      step(2);
      check_reset_values("rst");
      rst = 1'b0;

      // Single up call to 5
      call(3'd5);
      check("up_latch", 32'(pending), 32'h20);
      check("up_latch_state", 32'(st), 32'(S_IDLE));
      step(1);
      check("up_move", 32'(moving), 32'd1);
      check("up_door_closed", 32'(door), 32'd0);
      check("up_dir", 32'(direction), 32'd1);
      step(9);
      check("up_floor4", 32'(floor), 32'd4);
      check("up_still_moving", 32'(moving), 32'd1);
      step(1);
      check("up_floor5", 32'(floor), 32'd5);
      check("up_arrive_state", 32'(st), 32'(S_DOOR));
      check("up_arrive_door", 32'(door), 32'd1);
      check("up_arrive_pending", 32'(pending), 32'd0);
      wait_state(S_IDLE, 20, cyc);
      check("up_dwell_cycles", 32'(cyc), 32'd4);
      check("up_idle_pending", 32'(pending), 32'd0);

      // SCAN order: up to 6 then back down to 1
      do_reset();
      call(3'd6);
      wait_floor(3'd3, 20, cyc);
      check("scan_reach3", 32'(cyc), 32'd7);
      call(3'd1);
      check("scan_pending", 32'(pending), 32'h42);
      check("scan_dir_up", 32'(direction), 32'd1);
      wait_state(S_DOOR, 20, cyc);
      check("scan_to6_cycles", 32'(cyc), 32'd5);
      check("scan_stop6", 32'(floor), 32'd6);
      check("scan_pending_after6", 32'(pending), 32'h02);
      wait_state(S_IDLE, 20, cyc);
      check("scan_dwell6", 32'(cyc), 32'd4);
      step(1);
      check("scan_reverse_move", 32'(moving), 32'd1);
      check("scan_dir_down", 32'(direction), 32'd0);
      wait_state(S_DOOR, 30, cyc);
      check("scan_to1_cycles", 32'(cyc), 32'd10);
      check("scan_stop1", 32'(floor), 32'd1);
      check("scan_pending_empty", 32'(pending), 32'd0);
      wait_state(S_IDLE, 20, cyc);

      // Same-floor calls: go to 2, then call 2 while there
      call(3'd2);
      wait_state(S_DOOR, 20, cyc);
      check("same_to2_cycles", 32'(cyc), 32'd3);
      check("same_floor2", 32'(floor), 32'd2);
      wait_state(S_IDLE, 20, cyc);
      call(3'd2);
      check("same_open", 32'(st), 32'(S_DOOR));
      check("same_no_pending", 32'(pending), 32'd0);
      wait_state(S_IDLE, 20, cyc);
      check("same_dwell", 32'(cyc), 32'd4);
      call(3'd2);
      call(3'd2);
      check("restart_open", 32'(st), 32'(S_DOOR));
      wait_state(S_IDLE, 20, cyc);
      check("restart_dwell_tail", 32'(cyc), 32'd4);
      check("restart_pending", 32'(pending), 32'd0);

      // Emergency mid-travel toward 4
      do_reset();
      call(3'd4);
      step(1);
      check("emg_moving", 32'(moving), 32'd1);
      step(3);
      emergency  = 1'b1;
      call_valid = 1'b1;
      call_floor = 3'd7;
      step(1);
      check("emg_state", 32'(st), 32'(S_EMERG));
      check("emg_door", 32'(door), 32'd1);
      check("emg_moving_off", 32'(moving), 32'd0);
      check("emg_floor", 32'(floor), 32'd1);
      step(2);
      check("emg_pending_frozen", 32'(pending), 32'h10);
      check("emg_floor_frozen", 32'(floor), 32'd1);
      emergency  = 1'b0;
      call_valid = 1'b0;
      step(1);
      check("emg_release_idle", 32'(st), 32'(S_IDLE));
      check("emg_release_pending", 32'(pending), 32'h10);
      step(1);
      check("emg_resume_move", 32'(moving), 32'd1);
      check("emg_resume_dir", 32'(direction), 32'd1);
      wait_state(S_DOOR, 20, cyc);
      check("emg_resume_cycles", 32'(cyc), 32'd6);
      check("emg_resume_floor", 32'(floor), 32'd4);
      check("emg_resume_pending", 32'(pending), 32'd0);

      // Top floor: reach 7, then calls {7,0}
      do_reset();
      call(3'd7);
      wait_state(S_DOOR, 30, cyc);
      check("top_to7_cycles", 32'(cyc), 32'd15);
      check("top_floor7", 32'(floor), 32'd7);
      check("top_dir_forced", 32'(direction), 32'd0);
      wait_state(S_IDLE, 20, cyc);
      call(3'd7);
      check("top_same_open", 32'(st), 32'(S_DOOR));
      call(3'd0);
      check("top_pending0", 32'(pending), 32'h01);
      wait_state(S_IDLE, 20, cyc);
      check("top_dwell_tail", 32'(cyc), 32'd3);
      step(1);
      check("top_down_move", 32'(moving), 32'd1);
      check("top_down_dir", 32'(direction), 32'd0);
      cyc = 0;
      rises = 0;
      prev_floor = int'(floor);
      while (st !== S_DOOR && cyc < 40) begin
         step(1);
         cyc++;
         if (int'(floor) > prev_floor) rises++;
         prev_floor = int'(floor);
      end
      check("top_descent_cycles", 32'(cyc), 32'd14);
      check("top_descent_monotonic", 32'(rises), 32'd0);
      check("top_floor0", 32'(floor), 32'd0);

      // Out-of-range calls on the six-floor instance
      call_valid2 = 1'b1;
      call_floor2 = 3'd6;
      step(1);
      call_floor2 = 3'd7;
      step(1);
      call_valid2 = 1'b0;
      check("oor_pending", 32'(pending2), 32'd0);
      step(1);
      check("oor_no_move", 32'(moving2), 32'd0);
      call_valid2 = 1'b1;
      call_floor2 = 3'd5;
      step(1);
      call_valid2 = 1'b0;
      check("oor_valid_call", 32'(pending2), 32'h20);

      // Asynchronous reset during MOVE
      do_reset();
      call(3'd3);
      call(3'd6);
      step(2);
      check("areset_pre_pending", 32'(pending), 32'h48);
      check("areset_pre_moving", 32'(moving), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("areset");
      step(1);
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
